result_scorer: RTL and testbench
================================

# result_scorer

Downstream consumer of the neural-network datapath's 80-bit `ans` output, which holds ten signed 8-bit class scores. For each image, it captures the score vector together with its ground-truth label. It then scans the ten lanes serially to find the argmax, compares the winner with the label, and keeps running totals of images processed and images classified correctly. Once a configurable number of images has been scored, it raises a sticky `done`.

## Interface
- `NUM_IMAGES`, 750: number of images in one batch; `done` asserts when `image_count` reaches this value.
- `CNT_W`, 10: width of both counters; must satisfy 2^CNT_W > NUM_IMAGES.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `clr` input 1: synchronous batch restart.
- `ans_valid` input 1: `ans` and `label` are valid this cycle.
- `ans` input 80: class scores; lane i = `ans[8i+7:8i]`, signed two's complement, i = 0..9.
- `label` input 4: ground-truth class, 0..9.
- `ready` output 1: scorer can accept a new image this cycle.
- `pred_valid` output 1: one-cycle pulse when a prediction completes.
- `pred_index` output 4: argmax lane of the last scored image.
- `pred_correct` output 1: `pred_index == label` for the last image; valid with `pred_valid`, held afterwards.
- `image_count` output CNT_W: images scored since reset or `clr`.
- `correct_count` output CNT_W: correctly classified images since reset or `clr`.
- `done` output 1: sticky; batch complete.
- `label_err` output 1: sticky; some accepted label was greater than 9.

## Operation
- States are IDLE, SCAN, UPDATE and DONE.
- `ready` = (state == IDLE). It is combinational and never high in SCAN, UPDATE or DONE.
- **Accept (IDLE):** when `ans_valid` & `ready`, on the clock edge:
  - latch `ans` into `ans_reg` and `label` into `label_reg`;
  - set max = lane 0, idx = 0, lane counter = 1;
  - go to SCAN.
- `ans_valid` while not ready is ignored; there is no queueing. Upstream must hold `ans_valid` until it sees `ready`.
- **SCAN:** one lane per cycle, lanes 1..9.
  - If lane k > max (signed compare), then max ← lane k and idx ← k.
  - Ties keep the lower index.
  - After lane 9, go to UPDATE.
- **UPDATE:** on the clock edge, register the result:
  - `pred_index` ← idx, `pred_correct` ← (idx == `label_reg`);
  - `image_count` increments; `correct_count` increments if correct;
  - `pred_valid` pulses for exactly one cycle;
  - next state is DONE if the new `image_count` == `NUM_IMAGES`, else IDLE.
- **Bad label:** if `label_reg` > 9, the image counts as incorrect and `label_err` sets.
- **DONE:** all outputs hold, `done` = 1, and `ans_valid` is ignored. Only `clr` or `rst` leaves this state.
- **clr:** takes effect in any state and has priority over `ans_valid`.
  - The next state is IDLE.
  - `image_count`, `correct_count`, `done`, `label_err`, `pred_valid` and `pred_correct` all go to 0; `pred_index` also goes to 0.
  - A scan in progress is aborted: no `pred_valid` and no counter update.
- **Counters:** saturation is never reached, because DONE stops acceptance at `NUM_IMAGES`.

## Timing
- **Reset:** `rst` is asynchronous. While it is high, and immediately after it falls:
  - state = IDLE;
  - `ready` = 1;
  - `pred_valid` = 0, `pred_index` = 0, `pred_correct` = 0;
  - `image_count` = 0, `correct_count` = 0;
  - `done` = 0, `label_err` = 0.
- **Reset mid-operation:** `rst` asserted mid-scan discards the image immediately.
- **Latency** (accept at edge E0):
  - edges E1..E9 compare lanes 1..9;
  - state is UPDATE in the cycle after E9;
  - at edge E10, `pred_valid`, `pred_index`, `pred_correct` and the counters all update together;
  - `pred_valid` is high for the cycle following E10 only.
- **Throughput:** `ready` returns high after E10, so the earliest next accept is E11, i.e. one image per 11 cycles.
- **Counter/done alignment:** `done` rises at the same edge that `image_count` reaches `NUM_IMAGES`. That final `pred_valid` pulse still occurs.
- **`clr` and `ans_valid` together in IDLE:** `clr` wins; the image is not accepted.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle. Check all outputs go to their reset values at once and `ready` = 1.
- **Single image:** lanes {0:5, 1:-3, 2:40, 3:12, 4..9:0}, label 2. Expect:
  - `ready` low for E1..E10;
  - `pred_valid` one cycle after E10;
  - `pred_index` = 2, `pred_correct` = 1;
  - `image_count` = 1, `correct_count` = 1.
- **Signed and tie:** all lanes -128 except lanes 3 and 7 = -1, label 7. Expect `pred_index` = 3, `pred_correct` = 0, `correct_count` unchanged. Then all lanes equal → `pred_index` = 0.
- **Batch end:** set `NUM_IMAGES` = 4 and feed 4 images, 3 of them correct, back-to-back with `ans_valid` held high. Expect:
  - accepts spaced 11 cycles apart;
  - `done` = 1 with `image_count` = 4, `correct_count` = 3;
  - a 5th `ans_valid` ignored and counts unchanged.
- **clr mid-scan:** pulse `clr` 4 cycles after an accept. Expect no `pred_valid`, counters = 0, and `ready` = 1 on the next cycle. Repeat `clr` in DONE and check `done` clears.
- **Bad label:** label = 12 with lane 9 maximal. Expect `pred_index` = 9, `pred_correct` = 0, `label_err` = 1 sticky until `clr`.

Source files
------------

// File: rtl/result_scorer_if.sv
// rtl/result_scorer_if.sv - Score-vector input and prediction/statistics output bundle
interface result_scorer_if #(
    parameter int CNT_W = 10
);
    logic             ans_valid;
    logic [79:0]      ans;
    logic [3:0]       label;
    logic             ready;
    logic             pred_valid;
    logic [3:0]       pred_index;
    logic             pred_correct;
    logic [CNT_W-1:0] image_count;
    logic [CNT_W-1:0] correct_count;
    logic             done;
    logic             label_err;

    modport master (
        output ans_valid, ans, label,
        input  ready, pred_valid, pred_index, pred_correct,
        input  image_count, correct_count, done, label_err
    );

    modport slave (
        input  ans_valid, ans, label,
        output ready, pred_valid, pred_index, pred_correct,
        output image_count, correct_count, done, label_err
    );
endinterface

// File: rtl/result_scorer.sv
// rtl/result_scorer.sv - Serial argmax over ten signed 8-bit class scores with accuracy counters
module result_scorer #(
    parameter int NUM_IMAGES = 750,
    parameter int CNT_W      = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    result_scorer_if.slave  sb
);
    typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_IMAGES);
    localparam logic [3:0]       LAST_LANE  = 4'd9;

    state_t           state_q, state_d;
    logic [79:0]      ans_q, ans_d;
    logic [3:0]       label_q, label_d;
    logic signed [7:0] max_q, max_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       lane_q, lane_d;
    logic             pred_valid_q, pred_valid_d;
    logic [3:0]       pred_index_q, pred_index_d;
    logic             pred_correct_q, pred_correct_d;
    logic [CNT_W-1:0] img_q, img_d;
    logic [CNT_W-1:0] cor_q, cor_d;
    logic             label_err_q, label_err_d;

    logic signed [7:0] lane_val;
    logic              hit;
    logic [CNT_W-1:0]  img_inc;

    assign lane_val = ans_q[{lane_q, 3'b000} +: 8];
    // idx never exceeds 9, so an out-of-range label can never score as correct
    assign hit      = (idx_q == label_q);
    assign img_inc  = img_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        ans_d          = ans_q;
        label_d        = label_q;
        max_d          = max_q;
        idx_d          = idx_q;
        lane_d         = lane_q;
        pred_valid_d   = 1'b0;
        pred_index_d   = pred_index_q;
        pred_correct_d = pred_correct_q;
        img_d          = img_q;
        cor_d          = cor_q;
        label_err_d    = label_err_q;

        if (clr) begin
            state_d        = IDLE;
            pred_index_d   = 4'd0;
            pred_correct_d = 1'b0;
            img_d          = '0;
            cor_d          = '0;
            label_err_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sb.ans_valid) begin
                        ans_d   = sb.ans;
                        label_d = sb.label;
                        max_d   = sb.ans[7:0];
                        idx_d   = 4'd0;
                        lane_d  = 4'd1;
                        state_d = SCAN;
                    end
                end
                SCAN: begin
                    // strict greater-than keeps the lower index on ties
                    if (lane_val > max_q) begin
                        max_d = lane_val;
                        idx_d = lane_q;
                    end
                    lane_d = lane_q + 4'd1;
                    if (lane_q == LAST_LANE) begin
                        state_d = UPDATE;
                    end
                end
                UPDATE: begin
                    pred_valid_d   = 1'b1;
                    pred_index_d   = idx_q;
                    pred_correct_d = hit;
                    img_d          = img_inc;
                    if (hit) begin
                        cor_d = cor_q + 1'b1;
                    end
                    if (label_q > LAST_LANE) begin
                        label_err_d = 1'b1;
                    end
                    state_d = (img_inc == LAST_COUNT) ? DONE : IDLE;
                end
                DONE: begin
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            ans_q          <= '0;
            label_q        <= 4'd0;
            max_q          <= '0;
            idx_q          <= 4'd0;
            lane_q         <= 4'd0;
            pred_valid_q   <= 1'b0;
            pred_index_q   <= 4'd0;
            pred_correct_q <= 1'b0;
            img_q          <= '0;
            cor_q          <= '0;
            label_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            ans_q          <= ans_d;
            label_q        <= label_d;
            max_q          <= max_d;
            idx_q          <= idx_d;
            lane_q         <= lane_d;
            pred_valid_q   <= pred_valid_d;
            pred_index_q   <= pred_index_d;
            pred_correct_q <= pred_correct_d;
            img_q          <= img_d;
            cor_q          <= cor_d;
            label_err_q    <= label_err_d;
        end
    end

    assign sb.ready         = (state_q == IDLE);
    assign sb.done          = (state_q == DONE);
    assign sb.pred_valid    = pred_valid_q;
    assign sb.pred_index    = pred_index_q;
    assign sb.pred_correct  = pred_correct_q;
    assign sb.image_count   = img_q;
    assign sb.correct_count = cor_q;
    assign sb.label_err     = label_err_q;
endmodule

// File: tb/tb_result_scorer.sv
// tb/tb_result_scorer.sv - Directed vector bench for result_scorer
module tb_result_scorer;
    localparam int NUM_IMAGES = 4;
    localparam int CNT_W      = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    result_scorer_if #(.CNT_W(CNT_W)) bus ();

    result_scorer #(.NUM_IMAGES(NUM_IMAGES), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .sb  (bus.slave)
    );

    typedef struct {
        logic [79:0] ans;
        logic [3:0]  label;
        logic [3:0]  exp_idx;
        logic        exp_ok;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat;
    int ready_hi;
    int exp_img;
    int exp_cor;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [79:0] A_SINGLE = 80'h00_00_00_00_00_00_0C_28_FD_05;
    localparam logic [79:0] A_SIGNED = 80'h80_80_FF_80_80_80_FF_80_80_80;
    localparam logic [79:0] A_EQUAL  = 80'h11_11_11_11_11_11_11_11_11_11;
    localparam logic [79:0] A_LANE9  = 80'h64_05_05_05_05_05_05_05_05_05;
    localparam logic [79:0] A_MIXED  = 80'h00_00_00_80_7F_00_F0_00_00_00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drives one image through; returns with the sampling point on the pred_valid cycle
    task automatic run_image(input logic [79:0] a, input logic [3:0] l);
        @(negedge clk);
        bus.ans       = a;
        bus.label     = l;
        bus.ans_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.ans_valid = 1'b0;
        lat      = 1;
        ready_hi = 0;
        while (!bus.pred_valid && lat < 40) begin
            if (bus.ready) ready_hi++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        vec_t batch[4];
        int   acc[4];
        int   k;
        int   guard;
        int   pv_seen;

        vecs[0] = '{A_SINGLE, 4'd2, 4'd2, 1'b1};
        vecs[1] = '{A_SIGNED, 4'd7, 4'd3, 1'b0};
        vecs[2] = '{A_EQUAL,  4'd0, 4'd0, 1'b1};
        vecs[3] = '{A_MIXED,  4'd5, 4'd5, 1'b1};
        batch[0] = '{A_SINGLE, 4'd2, 4'd2, 1'b1};
        batch[1] = '{A_SIGNED, 4'd7, 4'd3, 1'b0};
        batch[2] = '{A_EQUAL,  4'd0, 4'd0, 1'b1};
        batch[3] = '{A_LANE9,  4'd9, 4'd9, 1'b1};

        bus.ans_valid = 1'b0;
        bus.ans       = '0;
        bus.label     = 4'd0;

        // asynchronous reset, checked mid-cycle while still asserted
        #1 rst = 1'b1;
        #2;
        check("rst_ready", bus.ready, 1);
        check("rst_pred_valid", bus.pred_valid, 0);
        check("rst_pred_index", bus.pred_index, 0);
        check("rst_pred_correct", bus.pred_correct, 0);
        check("rst_image_count", bus.image_count, 0);
        check("rst_correct_count", bus.correct_count, 0);
        check("rst_done", bus.done, 0);
        check("rst_label_err", bus.label_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // table of single images, NUM_IMAGES not reached (4 vectors, clr after 3)
        exp_img = 0;
        exp_cor = 0;
        for (int i = 0; i < 3; i++) begin
            run_image(vecs[i].ans, vecs[i].label);
            exp_img++;
            if (vecs[i].exp_ok) exp_cor++;
            check($sformatf("v%0d_latency", i), lat, 11);
            check($sformatf("v%0d_ready_low", i), ready_hi, 0);
            check($sformatf("v%0d_ready_back", i), bus.ready, 1);
            check($sformatf("v%0d_pred_index", i), bus.pred_index, vecs[i].exp_idx);
            check($sformatf("v%0d_pred_correct", i), bus.pred_correct, vecs[i].exp_ok);
            check($sformatf("v%0d_image_count", i), bus.image_count, exp_img);
            check($sformatf("v%0d_correct_count", i), bus.correct_count, exp_cor);
            @(negedge clk);
            check($sformatf("v%0d_pv_one_cycle", i), bus.pred_valid, 0);
            check($sformatf("v%0d_pc_held", i), bus.pred_correct, vecs[i].exp_ok);
        end

        pulse_clr();
        check("clr_image_count", bus.image_count, 0);
        check("clr_correct_count", bus.correct_count, 0);
        check("clr_pred_index", bus.pred_index, 0);
        check("clr_pred_correct", bus.pred_correct, 0);

        run_image(vecs[3].ans, vecs[3].label);
        check("mixed_pred_index", bus.pred_index, 5);
        check("mixed_correct_count", bus.correct_count, 1);

        // bad label: counts as incorrect, label_err sticks across a good image
        run_image(A_LANE9, 4'd12);
        check("bad_pred_index", bus.pred_index, 9);
        check("bad_pred_correct", bus.pred_correct, 0);
        check("bad_label_err", bus.label_err, 1);
        check("bad_correct_count", bus.correct_count, 1);
        check("bad_image_count", bus.image_count, 2);
        run_image(A_SINGLE, 4'd2);
        check("bad_sticky", bus.label_err, 1);
        check("bad_then_good", bus.pred_correct, 1);
        pulse_clr();
        check("bad_clr", bus.label_err, 0);

        // clr beats ans_valid in IDLE
        @(negedge clk);
        clr           = 1'b1;
        bus.ans       = A_SINGLE;
        bus.label     = 4'd2;
        bus.ans_valid = 1'b1;
        @(negedge clk);
        clr           = 1'b0;
        bus.ans_valid = 1'b0;
        check("clr_vs_valid_ready", bus.ready, 1);

        // clr four cycles after an accept aborts the scan
        run_image(A_SINGLE, 4'd2);
        check("pre_abort_count", bus.image_count, 1);
        @(negedge clk);
        bus.ans_valid = 1'b1;
        @(negedge clk);
        bus.ans_valid = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("abort_ready", bus.ready, 1);
        check("abort_image_count", bus.image_count, 0);
        check("abort_correct_count", bus.correct_count, 0);
        pv_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.pred_valid) pv_seen++;
        end
        check("abort_no_pred_valid", pv_seen, 0);

        // batch end with ans_valid held high
        k = 0;
        guard = 0;
        pv_seen = 0;
        @(negedge clk);
        bus.ans       = batch[0].ans;
        bus.label     = batch[0].label;
        bus.ans_valid = 1'b1;
        while (k < 4 && guard < 100) begin
            if (bus.ready) begin
                acc[k] = cyc;
                @(posedge clk);
                #1;
                k++;
                if (k < 4) begin
                    bus.ans   = batch[k].ans;
                    bus.label = batch[k].label;
                end else begin
                    bus.ans   = A_SINGLE;
                    bus.label = 4'd2;
                end
            end
            @(negedge clk);
            guard++;
        end
        check("batch_accepts", k, 4);
        for (int i = 1; i < 4; i++)
            check($sformatf("batch_spacing%0d", i), acc[i] - acc[i-1], 11);
        guard = 0;
        while (!bus.done && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("batch_done", bus.done, 1);
        check("batch_final_pv", bus.pred_valid, 1);
        check("batch_image_count", bus.image_count, 4);
        check("batch_correct_count", bus.correct_count, 3);
        check("batch_last_index", bus.pred_index, 9);
        pv_seen = 0;
        ready_hi = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.pred_valid) pv_seen++;
            if (bus.ready) ready_hi++;
        end
        check("done_ignores_valid", pv_seen, 0);
        check("done_ready_low", ready_hi, 0);
        check("done_image_hold", bus.image_count, 4);
        check("done_correct_hold", bus.correct_count, 3);
        check("done_sticky", bus.done, 1);
        bus.ans_valid = 1'b0;
        pulse_clr();
        check("done_clr", bus.done, 0);
        check("done_clr_count", bus.image_count, 0);
        check("done_clr_ready", bus.ready, 1);

        // asynchronous reset mid-scan
        run_image(A_LANE9, 4'd12);
        @(negedge clk);
        bus.ans_valid = 1'b1;
        @(negedge clk);
        bus.ans_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_ready", bus.ready, 1);
        check("midrst_image_count", bus.image_count, 0);
        check("midrst_pred_index", bus.pred_index, 0);
        check("midrst_label_err", bus.label_err, 0);
        @(negedge clk);
        rst = 1'b0;
        pv_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus.pred_valid) pv_seen++;
        end
        check("midrst_no_pred", pv_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
